game_sequencer: RTL and testbench

- Top-level game-flow controller for the dinosaur runner.
- Owns the IDLE/RUN/PAUSE/OVER state machine and drives the shared `pause` and active-low restart lines into the player and obstacle updaters.
- Schedules obstacle spawns with a pseudo-random interval and keeps the score.
- Runs on the game-tick clock clk3, the same clock the player updater advances on.

---
 rtl/game_sequencer_pkg.sv | 20 ++
 rtl/game_lfsr16.sv | 21 ++
 rtl/game_sequencer.sv | 117 +++++++++++
 tb/tb_game_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/game_sequencer_pkg.sv
// rtl/game_sequencer_pkg.sv - shared state encodings and LFSR constants for the game sequencer
package game_sequencer_pkg;

  typedef enum logic [1:0] {
    GS_IDLE  = 2'd0,
    GS_RUN   = 2'd1,
    GS_PAUSE = 2'd2,
    GS_OVER  = 2'd3
  } gs_state_t;

  localparam int          GS_SCORE_W   = 14;
  // Fibonacci taps 16,14,13,11 map to register bits 15,13,12,10
  localparam logic [15:0] GS_LFSR_TAPS = 16'hB400;
  localparam logic [15:0] GS_LFSR_SEED = 16'hACE1;

  function automatic logic [15:0] gs_lfsr_next(input logic [15:0] q);
    return {q[14:0], ^(q & GS_LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/game_lfsr16.sv
// rtl/game_lfsr16.sv - 16-bit Fibonacci LFSR with seed load on reset and step enable
module game_lfsr16
  import game_sequencer_pkg::*;
#(
  parameter logic [15:0] SEED = GS_LFSR_SEED
) (
  input  logic        clk3,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] q
);

  always_ff @(posedge clk3) begin
    if (!reset) begin
      q <= SEED;
    end else if (en) begin
      q <= gs_lfsr_next(q);
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - IDLE/RUN/PAUSE/OVER game flow, spawn scheduling and scoring
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int          SCORE_W    = GS_SCORE_W,
  parameter int          SCORE_DIV  = 6,
  parameter int          SPAWN_MIN  = 40,
  parameter int          SPAWN_MASK = 63,
  parameter int          OVER_HOLD  = 60,
  parameter logic [15:0] LFSR_SEED  = GS_LFSR_SEED
) (
  input  logic               clk3,
  input  logic               reset,
  input  logic               jump,
  input  logic               pause_btn,
  input  logic               collide,
  output logic               pause,
  output logic               game_reset,
  output logic               spawn,
  output logic [1:0]         spawn_kind,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         state
);

  localparam int CD_W   = $clog2(SPAWN_MIN + SPAWN_MASK + 1);
  localparam int DIV_W  = $clog2(SCORE_DIV + 1);
  localparam int HOLD_W = $clog2(OVER_HOLD + 1);

  gs_state_t         state_q, state_d;
  logic              start;
  logic              jump_q, pause_q;
  logic [CD_W-1:0]   cd;
  logic [DIV_W-1:0]  div;
  logic [HOLD_W-1:0] hold;
  logic [15:0]       lfsr;

  wire jump_press  = jump_q & ~jump;
  wire pause_press = pause_q & ~pause_btn;

  game_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk3  (clk3),
    .reset (reset),
    .en    (1'b1),
    .q     (lfsr)
  );

  always_ff @(posedge clk3) begin
    if (!reset) state_q <= GS_IDLE;
    else        state_q <= state_d;
  end

  // start marks entry into RUN from IDLE or OVER; it drives the restart pulse
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      GS_IDLE: if (jump_press) begin
        state_d = GS_RUN;
        start   = 1'b1;
      end
      GS_RUN: begin
        if (collide)          state_d = GS_OVER;
        else if (pause_press) state_d = GS_PAUSE;
      end
      GS_PAUSE: if (pause_press) state_d = GS_RUN;
      GS_OVER: if (jump_press && hold == HOLD_W'(OVER_HOLD)) begin
        state_d = GS_RUN;
        start   = 1'b1;
      end
      default: state_d = GS_IDLE;
    endcase
  end

  always_ff @(posedge clk3) begin
    if (!reset) begin
      score      <= '0;
      spawn      <= 1'b0;
      spawn_kind <= 2'd0;
      game_reset <= 1'b0;
      cd         <= CD_W'(SPAWN_MIN);
      div        <= '0;
      hold       <= '0;
      jump_q     <= 1'b1;
      pause_q    <= 1'b1;
    end else begin
      jump_q     <= jump;
      pause_q    <= pause_btn;
      game_reset <= ~start;
      spawn      <= 1'b0;
      if (start) begin
        score <= '0;
        div   <= '0;
        cd    <= CD_W'(SPAWN_MIN);
      end else if (state_q == GS_RUN) begin
        if (div == DIV_W'(SCORE_DIV - 1)) begin
          div <= '0;
          if (score != '1) score <= score + 1'b1;
        end else begin
          div <= div + 1'b1;
        end
        if (cd == '0) begin
          spawn      <= 1'b1;
          spawn_kind <= lfsr[1:0];
          cd         <= CD_W'(SPAWN_MIN) + CD_W'(lfsr & 16'(SPAWN_MASK));
        end else begin
          cd <= cd - 1'b1;
        end
      end
      if (state_q == GS_RUN && collide)                         hold <= '0;
      else if (state_q == GS_OVER && hold != HOLD_W'(OVER_HOLD)) hold <= hold + 1'b1;
    end
  end

  assign pause = (state_q != GS_RUN);
  assign state = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - scoreboard bench for game_sequencer with directed stimulus
module tb_game_sequencer;

  localparam int          SW    = 4;
  localparam int          SDIV  = 2;
  localparam int          SMIN  = 5;
  localparam int          SMASK = 0;
  localparam int          HOLD  = 4;
  localparam logic [15:0] SEED  = 16'h0001;

  logic          clk3 = 1'b0;
  logic          reset = 1'b0;
  logic          jump = 1'b1;
  logic          pause_btn = 1'b1;
  logic          collide = 1'b0;
  logic          pause, game_reset, spawn;
  logic [1:0]    spawn_kind;
  logic [SW-1:0] score;
  logic [1:0]    state;

  game_sequencer #(
    .SCORE_W(SW), .SCORE_DIV(SDIV), .SPAWN_MIN(SMIN),
    .SPAWN_MASK(SMASK), .OVER_HOLD(HOLD), .LFSR_SEED(SEED)
  ) dut (
    .clk3(clk3), .reset(reset), .jump(jump), .pause_btn(pause_btn),
    .collide(collide), .pause(pause), .game_reset(game_reset),
    .spawn(spawn), .spawn_kind(spawn_kind), .score(score), .state(state)
  );

  always #5 clk3 = ~clk3;

  typedef struct {int cyc; string name; int sel; int val;} exp_t;
  typedef struct {int cyc; int kind;} spn_t;
  exp_t exp_q[$];
  spn_t spn_q[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always @(posedge clk3) cyc <= cyc + 1;

  // reference LFSR: Fibonacci taps 16,14,13,11
  logic [15:0] m_lfsr, m_prev;
  always @(posedge clk3) begin
    m_prev <= m_lfsr;
    m_lfsr <= reset ? {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]} : SEED;
  end

  int m_st = 0, m_sc = 0, m_div = 0, m_cd = SMIN, m_hold = 0, m_gr = 0;
  logic m_jq = 1'b1, m_pq = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int obs(input int sel);
    case (sel)
      0: return int'(state);
      1: return int'(score);
      2: return int'(game_reset);
      default: return int'(pause);
    endcase
  endfunction

  task automatic push(input string name, input int sel, input int val);
    exp_q.push_back('{cyc, name, sel, val});
  endtask

  always @(negedge clk3) begin
    exp_t e;
    spn_t s;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      check(e.name, obs(e.sel), e.val);
    end
    if (spawn) begin
      if (spn_q.size() > 0 && spn_q[0].cyc == cyc) begin
        s = spn_q.pop_front();
        check("spawn_kind", int'(spawn_kind), s.kind);
      end else begin
        check("spawn_unexpected", int'(spawn), 0);
      end
    end else if (spn_q.size() > 0 && spn_q[0].cyc <= cyc) begin
      s = spn_q.pop_front();
      check("spawn_missing", int'(spawn), 1);
    end
  end

  // apply one tick of inputs, advance the model, queue the expected outputs
  task automatic step(input logic j, input logic p, input logic c, input logic r);
    logic jp, pp, spw;
    jump = j; pause_btn = p; collide = c; reset = r;
    @(posedge clk3); #1;
    jp = m_jq & ~j;
    pp = m_pq & ~p;
    spw = 1'b0;
    if (!r) begin
      m_st = 0; m_sc = 0; m_div = 0; m_cd = SMIN; m_hold = 0; m_gr = 0;
      m_jq = 1'b1; m_pq = 1'b1;
    end else begin
      m_gr = 1;
      case (m_st)
        0: if (jp) begin m_st = 1; m_sc = 0; m_div = 0; m_cd = SMIN; m_gr = 0; end
        1: begin
          if (m_div == SDIV - 1) begin
            m_div = 0;
            if (m_sc != (1 << SW) - 1) m_sc++;
          end else m_div++;
          if (m_cd == 0) begin
            spw = 1'b1;
            m_cd = SMIN + (int'(m_prev) & SMASK);
          end else m_cd--;
          if (c) begin m_st = 3; m_hold = 0; end
          else if (pp) m_st = 2;
        end
        2: if (pp) m_st = 1;
        default: begin
          if (jp && m_hold == HOLD) begin
            m_st = 1; m_sc = 0; m_div = 0; m_cd = SMIN; m_gr = 0;
          end else if (m_hold < HOLD) m_hold++;
        end
      endcase
      m_jq = j; m_pq = p;
    end
    push("state", 0, m_st);
    push("score", 1, m_sc);
    push("game_reset", 2, m_gr);
    push("pause", 3, (m_st != 1) ? 1 : 0);
    if (spw) spn_q.push_back('{cyc, int'(m_prev[1:0])});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end of stimulus");
    $fatal(1);
  end

  initial begin
    // reset, then start
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    push("reset_state", 0, 0);
    push("reset_pause", 3, 1);
    step(0, 1, 0, 1);
    push("start_state", 0, 1);
    push("start_game_reset_low", 2, 0);
    push("start_pause", 3, 0);
    step(1, 1, 0, 1);
    push("start_game_reset_high", 2, 1);

    // score saturation and periodic spawns
    for (int i = 0; i < 40; i++) step(1, 1, 0, 1);
    push("score_saturated", 1, 15);

    // collide wins over a same-tick pause press
    step(1, 0, 1, 1);
    push("collide_priority", 0, 3);

    // over hold: early jump ignored, jump at full hold restarts
    for (int i = 0; i < HOLD - 1; i++) step(1, 1, 0, 1);
    step(0, 1, 0, 1);
    push("over_early_jump", 0, 3);
    step(1, 1, 0, 1);
    step(0, 1, 0, 1);
    push("over_restart_state", 0, 1);
    push("over_restart_score", 1, 0);
    push("over_restart_game_reset", 2, 0);

    // reach score 7, pause, then reset mid-operation
    for (int i = 0; i < 13; i++) step(1, 1, 0, 1);
    step(1, 0, 0, 1);
    push("pause_state", 0, 2);
    push("pause_score7", 1, 7);
    step(1, 0, 0, 1);
    push("pause_held_once", 0, 2);
    for (int i = 0; i < 8; i++) step(1, 1, 1, 1);
    push("pause_ignores_collide", 0, 2);
    step(1, 1, 0, 0);
    push("midreset_state", 0, 0);
    push("midreset_score", 1, 0);
    push("midreset_game_reset", 2, 0);
    push("midreset_pause", 3, 1);

    // pause freeze and resume with the same values
    step(0, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1);
    step(1, 0, 0, 1);
    push("freeze_score", 1, 2);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 1);
    step(1, 0, 0, 1);
    push("resume_state", 0, 1);
    push("resume_score", 1, 2);
    for (int i = 0; i < 12; i++) step(1, 1, 0, 1);

    @(negedge clk3);
    @(negedge clk3);
    check("exp_queue_drained", exp_q.size(), 0);
    check("spawn_queue_drained", spn_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
